// File: rtl/trim_rx.sv
// trim_rx -- serial trim-code receiver.
//
// Purpose: captures a 12-bit trim code sent LSB first on SDIN and clocked
// by the falling edges of SCLK. SCLK is asynchronous to CLK50, so both lines
// are synchronised and the falling edges are detected in the CLK50 domain.
// Each complete frame updates TRIMCODE and pulses VALID. A frame that stalls
// for TIMEOUT_CYCLES is aborted and FRAME_ERR pulses.
//
// Optional feature: define TRIM_RX_PARITY_EN for a 13-bit frame, made of
// 12 data bits followed by an odd-parity bit. A frame that fails the parity
// check pulses FRAME_ERR instead of VALID.
//
// Ports:
//   CLK50     in   system clock; all logic uses its rising edge
//   RST       in   asynchronous reset, active high
//   EN        in   receive enable; while low the receiver stays in IDLE
//   SCLK      in   serial gated clock, idle low
//   SDIN      in   serial data, LSB first
//   TRIMCODE  out  [11:0] last code that was received correctly
//   VALID     out  one-cycle pulse when TRIMCODE updates
//   BUSY      out  high while a frame is partly received
//   FRAME_ERR out  one-cycle pulse on a timed-out or rejected frame
//
// state | meaning
// IDLE  | waiting for the first SCLK falling edge of a frame
// SHIFT | frame partly received, timeout counter running
// LATCH | one cycle after the final bit; VALID/FRAME_ERR visible
module trim_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 75000000
) (
  input  logic        CLK50,
  input  logic        RST,
  input  logic        EN,
  input  logic        SCLK,
  input  logic        SDIN,
  output logic [11:0] TRIMCODE,
  output logic        VALID,
  output logic        BUSY,
  output logic        FRAME_ERR
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef TRIM_RX_PARITY_EN
  localparam int unsigned FRAME_LEN = 13;
`else
  localparam int unsigned FRAME_LEN = 12;
`endif
  // The shift register spans the whole frame. In parity builds the parity
  // bit ends up in bit 12 and the data ends up in bits 11:0.
  localparam int unsigned SR_W = FRAME_LEN;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t            state_q, state_d;
  logic              sclk_s1, sclk_s2, sclk_s3;
  logic              sdin_s1, sdin_s2;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [11:0]       trim_q, trim_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              sclk_fall;

  assign sclk_fall = sclk_s3 & ~sclk_s2;

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_s3   <= 1'b0;
      sdin_s1   <= 1'b0;
      sdin_s2   <= 1'b0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      sr_q      <= '0;
      trim_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sclk_s1   <= SCLK;
      sclk_s2   <= sclk_s1;
      sclk_s3   <= sclk_s2;
      sdin_s1   <= SDIN;
      sdin_s2   <= sdin_s1;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      sr_q      <= sr_d;
      trim_q    <= trim_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // TRIMCODE and the VALID/FRAME_ERR pulses are registered when the FSM
  // moves into LATCH. They are therefore visible during the LATCH cycle,
  // which is the cycle after the detection of the final edge.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    sr_d      = sr_q;
    trim_d    = trim_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (!EN) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      to_cnt_d  = '0;
    end else begin
      case (state_q)
        // An edge seen in LATCH is the first bit of the next frame.
        IDLE, LATCH: begin
          to_cnt_d = '0;
          if (sclk_fall) begin
            sr_d      = {sdin_s2, sr_q[SR_W-1:1]};
            bit_cnt_d = 4'd1;
            state_d   = SHIFT;
          end else begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end
        end
        SHIFT: begin
          if (sclk_fall) begin
            // An edge takes priority over a timeout in the same cycle.
            sr_d     = {sdin_s2, sr_q[SR_W-1:1]};
            to_cnt_d = '0;
            if (bit_cnt_q == 4'(FRAME_LEN - 1)) begin
              bit_cnt_d = '0;
              state_d   = LATCH;
`ifdef TRIM_RX_PARITY_EN
              if (^sr_d) begin
                trim_d  = sr_d[11:0];
                valid_d = 1'b1;
              end else begin
                err_d   = 1'b1;
              end
`else
              trim_d  = sr_d[11:0];
              valid_d = 1'b1;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // to_cnt_q is zero in the first cycle after an edge, so this
            // branch fires on the TIMEOUT_CYCLES-th idle cycle.
            state_d   = IDLE;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            err_d     = 1'b1;
          end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end
      endcase
    end
  end

  assign TRIMCODE  = trim_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = err_q;
  assign BUSY      = (state_q == SHIFT);

endmodule

// File: doc/trim_rx.md
TRIM_RX -- requirements
Module: trim_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 75000000, meaning the number of CLK50 cycles without an SCLK falling edge that aborts a partial frame.
REQ-002 SHALL have port CLK50  input  1  system clock, 50 MHz, all logic on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port EN  input  1  receive enable; low forces IDLE and ignores SCLK.
REQ-005 SHALL have port SCLK  input  1  serial gated clock from the trim generator, asynchronous to CLK50, idle low.
REQ-006 SHALL have port SDIN  input  1  serial trim data, LSB first, stable around SCLK falling edge.
REQ-007 SHALL have port TRIMCODE  output  12  last successfully received trim code.
REQ-008 SHALL have port VALID  output  1  one-cycle pulse when TRIMCODE updates.
REQ-009 SHALL have port BUSY  output  1  high while a frame is partially received.
REQ-010 SHALL have port FRAME_ERR  output  1  one-cycle pulse on aborted or rejected frame.

Function
REQ-011 SHALL pass SCLK and SDIN through two-flop synchronizers; falling edge = previous synced SCLK 1, current 0.
REQ-012 SHALL sample synced SDIN on the detection cycle of each SCLK falling edge; rising edges are ignored.
REQ-013 SHALL shift right into a 12-bit register: new bit enters bit 11, so the first bit received lands in bit 0 after 12 bits.
REQ-014 SHALL implement states IDLE, SHIFT, LATCH; IDLE->SHIFT on first edge (bit count 1); SHIFT->LATCH when bit count reaches frame length; LATCH->IDLE after one cycle.
REQ-015 SHALL, in LATCH, load TRIMCODE from the shift register and assert VALID for exactly one CLK50 cycle, one cycle after the final edge's detection cycle.
REQ-016 SHALL treat an edge detected during LATCH as bit 0 of a new frame (next state SHIFT, count 1), with no lost bit.
REQ-017 SHALL count CLK50 cycles since last edge in SHIFT; at TIMEOUT_CYCLES, return to IDLE, clear bit count, pulse FRAME_ERR, leave TRIMCODE unchanged.
REQ-018 SHALL give an edge priority over timeout when both occur in the same cycle (counter reset, bit accepted).
REQ-019 SHALL assert BUSY exactly in SHIFT.
REQ-020 SHALL, on EN low, go to IDLE within one cycle, clear bit count and timeout counter, no VALID or FRAME_ERR; TRIMCODE holds.
REQ-021 SHALL size the timeout counter as ceil(log2(TIMEOUT_CYCLES+1)) bits, saturating without wrap.

Reset
REQ-022 SHALL, on RST high, immediately clear TRIMCODE to 12'h000, VALID/BUSY/FRAME_ERR to 0, synchronizers to 0, state IDLE, all counters 0.
REQ-023 SHALL discard any partial frame on reset mid-operation; first edge after release starts a new frame.

Configuration
REQ-024 SHALL, with macro TRIM_RX_PARITY_EN defined, use a 13-bit frame: 12 data bits then one odd-parity bit over the 12 data bits.
REQ-025 SHALL, with TRIM_RX_PARITY_EN defined, on parity mismatch in LATCH, pulse FRAME_ERR instead of VALID and keep TRIMCODE.
REQ-026 SHALL, without TRIM_RX_PARITY_EN, use a 12-bit frame with no parity logic present.

Verification (TIMEOUT_CYCLES=100, SCLK period 20 CLK50 cycles)
REQ-027 SHALL cover: 12 bits of 12'hA5C LSB first -> one VALID pulse, TRIMCODE=12'hA5C, BUSY low after.
REQ-028 SHALL cover: 5 bits then SCLK idle 100 cycles -> FRAME_ERR pulse, BUSY low, TRIMCODE unchanged; next full frame 12'h001 -> TRIMCODE=12'h001.
REQ-029 SHALL cover: back-to-back frames 12'hFFF then 12'h000 with first edge of frame 2 in LATCH -> two VALID pulses, final TRIMCODE=12'h000.
REQ-030 SHALL cover: RST asserted after bit 7 of 12'h3C3 -> outputs zero immediately; following frame 12'h3C3 -> TRIMCODE=12'h3C3.
REQ-031 SHALL cover: EN low during bits 3-6 -> no VALID, BUSY low; EN high then full frame 12'h800 -> TRIMCODE=12'h800.
REQ-032 SHALL cover, with TRIM_RX_PARITY_EN: 12'h007 with parity 0 -> VALID; same data with parity 1 -> FRAME_ERR, TRIMCODE stays 12'h007.
